// File: rtl/rv_pkg.sv
// Shared RISC-V writeback definitions: data/register widths and the load funct3 encodings.
package rv_pkg;

  localparam int RV_XLEN    = 32;
  localparam int RV_RADDR_W = 5;

  typedef logic [RV_RADDR_W-1:0] reg_num_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_e;

endpackage

// File: rtl/writeback_arbiter_load_align.sv
// Combinational load data aligner: selects byte/half/word by address offset and extends it.
module load_align
  import rv_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic [31:0]     data_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] value_o,
  output logic            error_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = data_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = data_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    value_o = '0;
    error_o = 1'b0;
    case (funct3_i)
      F3_LB:  value_o = XLEN'($signed(byte_sel));
      F3_LBU: value_o = XLEN'(byte_sel);
      F3_LH: begin
        value_o = XLEN'($signed(half_sel));
        error_o = addr_lo_i[0];
      end
      F3_LHU: begin
        value_o = XLEN'(half_sel);
        error_o = addr_lo_i[0];
      end
      F3_LW: begin
        value_o = XLEN'($signed(data_i));
        error_o = (addr_lo_i != 2'b00);
      end
      default: error_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: loads own the register file port; ALU results queue in a small FIFO
// and are exported as a busy mask for hazard detection.
module writeback_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN      = RV_XLEN,
  parameter int RADDR_W   = RV_RADDR_W,
  parameter int ALU_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [RADDR_W-1:0]    alu_rd,
  input  logic [XLEN-1:0]       alu_value,
  input  logic                  mem_valid,
  input  logic [RADDR_W-1:0]    mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic [2:0]            mem_funct3,
  input  logic [1:0]            mem_addr_lo,
  output logic                  out_write_enable,
  output logic [RADDR_W-1:0]    out_write_number,
  output logic [XLEN-1:0]       out_write_value,
  output logic                  out_load_error,
  output logic [2**RADDR_W-1:0] out_busy_mask
);

  localparam int PTR_W = (ALU_DEPTH > 1) ? $clog2(ALU_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**RADDR_W;

  // FIFO storage (no reset: only entries covered by count_q are ever read)
  logic [RADDR_W-1:0] fifo_rd_mem  [ALU_DEPTH];
  logic [XLEN-1:0]    fifo_val_mem [ALU_DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic               we_q, we_d;
  logic [RADDR_W-1:0] num_q, num_d;
  logic [XLEN-1:0]    val_q, val_d;
  logic               err_q, err_d;

  logic            accept;
  logic            alu_keep;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] load_value;
  logic            load_error;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .data_i   (mem_data[31:0]),
    .funct3_i (mem_funct3),
    .addr_lo_i(mem_addr_lo),
    .value_o  (load_value),
    .error_o  (load_error)
  );

  assign alu_ready = (count_q < CNT_W'(ALU_DEPTH));
  assign accept    = alu_valid && alu_ready;
  // x0 results are consumed here and never enter the queue
  assign alu_keep  = accept && (alu_rd != '0);

  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    we_d  = 1'b0;
    num_d = '0;
    val_d = '0;
    err_d = 1'b0;
    if (mem_valid) begin
      we_d  = !load_error && (mem_rd != '0);
      num_d = mem_rd;
      val_d = load_value;
      err_d = load_error;
      push  = alu_keep;
    end else if (count_q != '0) begin
      pop   = 1'b1;
      we_d  = 1'b1;
      num_d = fifo_rd_mem[head_q];
      val_d = fifo_val_mem[head_q];
      push  = alu_keep;
    end else if (accept) begin
      we_d  = alu_keep;
      num_d = alu_rd;
      val_d = alu_value;
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      num_q   <= '0;
      val_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      num_q   <= num_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[tail_q]  <= alu_rd;
      fifo_val_mem[tail_q] <= alu_value;
    end
  end

  logic [NREG-1:0] entry_mask [ALU_DEPTH];

  generate
    for (genvar gi = 0; gi < ALU_DEPTH; gi++) begin : g_busy
      logic [PTR_W-1:0] offset;
      logic             live;
      // An entry is live when its distance from head is inside the occupied count
      assign offset          = PTR_W'(gi) - head_q;
      assign live            = ({1'b0, offset} < count_q);
      assign entry_mask[gi]  = live ? (NREG'(1) << fifo_rd_mem[gi]) : '0;
    end
  endgenerate

  always_comb begin
    out_busy_mask = '0;
    for (int i = 0; i < ALU_DEPTH; i++) begin
      out_busy_mask = out_busy_mask | entry_mask[i];
    end
    out_busy_mask[0] = 1'b0;
  end

  assign out_write_enable = we_q;
  assign out_write_number = num_q;
  assign out_write_value  = val_q;
  assign out_load_error   = err_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, bypass, contention, load extension, errors, x0.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_addr_lo;
  logic        out_write_enable;
  logic [4:0]  out_write_number;
  logic [31:0] out_write_value;
  logic        out_load_error;
  logic [31:0] out_busy_mask;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  writeback_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_value       (alu_value),
    .mem_valid       (mem_valid),
    .mem_rd          (mem_rd),
    .mem_data        (mem_data),
    .mem_funct3      (mem_funct3),
    .mem_addr_lo     (mem_addr_lo),
    .out_write_enable(out_write_enable),
    .out_write_number(out_write_number),
    .out_write_value (out_write_value),
    .out_load_error  (out_load_error),
    .out_busy_mask   (out_busy_mask)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input logic we, input logic [4:0] num,
                              input logic [31:0] val);
    chk({tag, ".we"}, 32'(out_write_enable), 32'(we));
    if (we) begin
      chk({tag, ".num"}, 32'(out_write_number), 32'(num));
      chk({tag, ".val"}, out_write_value, val);
    end
  endtask

  task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [31:0] d,
                           input logic [2:0] f3, input logic [1:0] off);
    mem_valid = v; mem_rd = rd; mem_data = d; mem_funct3 = f3; mem_addr_lo = off;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] val);
    alu_valid = v; alu_rd = rd; alu_value = val;
  endtask

  // Load-extension vectors: funct3, offset, expected value
  logic [2:0]  ext_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  ext_off [5] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
  logic [31:0] ext_exp [5] = '{32'hFFFF_FF80, 32'h0000_00F0, 32'hFFFF_80F0,
                               32'h0000_7F01, 32'h80F0_7F01};
  // Error vectors: funct3, offset
  logic [2:0]  err_f3  [3] = '{3'b010, 3'b001, 3'b011};
  logic [1:0]  err_off [3] = '{2'd1, 2'd3, 2'd0};

  initial begin
    rst = 1'b1;
    drive_alu(1'b1, 5'd3, 32'hDEAD_BEEF);
    drive_mem(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);

    // Reset held 3 cycles with an ALU offer: nothing written
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst%0d.we", i), 32'(out_write_enable), 32'd0);
      chk($sformatf("rst%0d.num", i), 32'(out_write_number), 32'd0);
      chk($sformatf("rst%0d.val", i), out_write_value, 32'd0);
      chk($sformatf("rst%0d.err", i), 32'(out_load_error), 32'd0);
      chk($sformatf("rst%0d.busy", i), out_busy_mask, 32'd0);
    end
    rst = 1'b0;
    drive_alu(1'b0, 5'd0, 32'h0);
    chk("rst.ready", 32'(alu_ready), 32'd1);
    tick();
    chk("post_rst.we", 32'(out_write_enable), 32'd0);
    chk("post_rst.ready", 32'(alu_ready), 32'd1);

    // Bypass
    drive_alu(1'b1, 5'd5, 32'h0000_1234);
    tick();
    drive_alu(1'b0, 5'd0, 32'h0);
    expect_write("bypass", 1'b1, 5'd5, 32'h0000_1234);
    chk("bypass.busy", out_busy_mask, 32'd0);
    tick();
    chk("bypass_idle.we", 32'(out_write_enable), 32'd0);

    // Contention: loads win, ALU results queue and drain in order
    drive_mem(1'b1, 5'd1, 32'h11, 3'b010, 2'd0);
    drive_alu(1'b1, 5'd7, 32'h77);
    tick();
    expect_write("cont0", 1'b1, 5'd1, 32'h11);
    chk("cont0.busy", out_busy_mask, 32'h080);
    chk("cont0.ready", 32'(alu_ready), 32'd1);
    drive_mem(1'b1, 5'd2, 32'h22, 3'b010, 2'd0);
    drive_alu(1'b1, 5'd8, 32'h88);
    tick();
    expect_write("cont1", 1'b1, 5'd2, 32'h22);
    chk("cont1.busy", out_busy_mask, 32'h180);
    chk("cont1.ready", 32'(alu_ready), 32'd0);
    drive_mem(1'b1, 5'd3, 32'h33, 3'b010, 2'd0);
    drive_alu(1'b0, 5'd0, 32'h0);
    tick();
    expect_write("cont2", 1'b1, 5'd3, 32'h33);
    chk("cont2.busy", out_busy_mask, 32'h180);
    chk("cont2.ready", 32'(alu_ready), 32'd0);
    drive_mem(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
    tick();
    expect_write("cont3", 1'b1, 5'd7, 32'h77);
    chk("cont3.busy", out_busy_mask, 32'h100);
    chk("cont3.ready", 32'(alu_ready), 32'd1);
    tick();
    expect_write("cont4", 1'b1, 5'd8, 32'h88);
    chk("cont4.busy", out_busy_mask, 32'd0);
    tick();
    chk("cont5.we", 32'(out_write_enable), 32'd0);

    // Load extension
    for (int i = 0; i < 5; i++) begin
      drive_mem(1'b1, 5'd10, 32'h80F0_7F01, ext_f3[i], ext_off[i]);
      tick();
      expect_write($sformatf("ext%0d", i), 1'b1, 5'd10, ext_exp[i]);
      chk($sformatf("ext%0d.err", i), 32'(out_load_error), 32'd0);
    end

    // Errors: pulse, no write; ALU offered in the last error cycle gets queued
    for (int i = 0; i < 3; i++) begin
      drive_mem(1'b1, 5'd11, 32'h80F0_7F01, err_f3[i], err_off[i]);
      if (i == 2) drive_alu(1'b1, 5'd9, 32'h99);
      tick();
      chk($sformatf("err%0d.err", i), 32'(out_load_error), 32'd1);
      chk($sformatf("err%0d.we", i), 32'(out_write_enable), 32'd0);
    end
    drive_mem(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
    drive_alu(1'b0, 5'd0, 32'h0);
    chk("err.busy", out_busy_mask, 32'h200);
    tick();
    chk("err_end.err", 32'(out_load_error), 32'd0);
    expect_write("err_drain", 1'b1, 5'd9, 32'h99);
    chk("err_drain.busy", out_busy_mask, 32'd0);

    // x0 from both sources
    drive_mem(1'b1, 5'd0, 32'h5555_AAAA, 3'b010, 2'd0);
    drive_alu(1'b1, 5'd0, 32'h1111);
    tick();
    drive_mem(1'b0, 5'd0, 32'h0, 3'b010, 2'd0);
    drive_alu(1'b0, 5'd0, 32'h0);
    chk("x0.we", 32'(out_write_enable), 32'd0);
    chk("x0.err", 32'(out_load_error), 32'd0);
    chk("x0.busy", out_busy_mask, 32'd0);
    chk("x0.ready", 32'(alu_ready), 32'd1);
    tick();
    chk("x0_after.we", 32'(out_write_enable), 32'd0);
    chk("x0_after.ready", 32'(alu_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
